// File: rtl/ekf_sched_pkg.sv
// Shared types and constants for the EKF-SLAM stage scheduler:
// FSM state encoding, stage index names and sticky error bit positions.
package ekf_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_RUN
   } sched_state_t;

   localparam int STG_PREDICT = 0;
   localparam int STG_NEWLM   = 1;
   localparam int STG_UPDATE  = 2;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_ONEHOT  = 1;

endpackage

// File: rtl/ekf_req_fifo.sv
// Request queue for the stage scheduler: circular buffer with a registered
// occupancy count; full/empty are decoded from that count only.
module ekf_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Simultaneous push and pop leave the level untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + (AW+1)'(1);
         else if (do_pop && !do_push) level <= level - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ekf_stage_sched.sv
// Stage scheduler between the PS request port and the EKF engines: queues
// one-hot requests, fetches operands from PLB BRAM, pulses init, waits for done.
module ekf_stage_sched
   import ekf_sched_pkg::*;
#(
   parameter int DW      = 32,
   parameter int PLB_AW  = 10,
   parameter int ROW_LEN = 10,
   parameter int N_STAGE = 3,
   parameter int Q_DEPTH = 4,
   parameter int OPND_N  = 2,
   parameter int TO_W    = 16
) (
   input  logic                     clk,
   input  logic                     sys_rst,
   input  logic [N_STAGE-1:0]       stage_val,
   output logic [N_STAGE-1:0]       stage_rdy,
   input  logic [ROW_LEN-1:0]       l_k,
   input  logic [PLB_AW-1:0]        opnd_base,
   output logic                     PLB_en,
   output logic                     PLB_we,
   output logic [PLB_AW-1:0]        PLB_addr,
   input  logic [DW-1:0]            PLB_din,
   output logic [N_STAGE-1:0]       init,
   output logic [OPND_N*DW-1:0]     opnd_data,
   output logic [ROW_LEN-1:0]       opnd_lk,
   input  logic [N_STAGE-1:0]       done,
   output logic                     busy,
   output logic [$clog2(Q_DEPTH):0] q_level,
   output logic [1:0]               err
);

   localparam int SW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
   localparam int KW = $clog2(OPND_N + 1);
   localparam int EW = SW + ROW_LEN;
   localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   sched_state_t        state;
   sched_state_t        next_state;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                pop;
   logic [EW-1:0]       fifo_rdata;
   logic                req_onehot;
   logic [SW-1:0]       req_idx;
   logic [SW-1:0]       cur_idx;
   logic [ROW_LEN-1:0]  cur_lk;
   logic [N_STAGE-1:0]  sel_mask;
   logic [KW-1:0]       k_cnt;
   logic [TO_W-1:0]     wd_cnt;
   logic [PLB_AW-1:0]   stage_off;
   logic                timeout;

   // The x & (x-1) trick clears the lowest set bit, so zero means one-hot.
   always_comb begin
      req_onehot = (stage_val != '0) &&
                   ((stage_val & (stage_val - N_STAGE'(1))) == '0);
      req_idx = '0;
      for (int i = 0; i < N_STAGE; i++) begin
         if (stage_val[i]) req_idx = SW'(i);
      end
   end

   assign fifo_push = req_onehot && !fifo_full;
   assign stage_rdy = {N_STAGE{~fifo_full}};
   assign busy      = (state != ST_IDLE) || !fifo_empty;
   assign PLB_we    = 1'b0;
   assign sel_mask  = N_STAGE'(1) << cur_idx;
   assign stage_off = PLB_AW'(cur_idx) * PLB_AW'(OPND_N);

   ekf_req_fifo #(
      .DEPTH (Q_DEPTH),
      .W     (EW)
   ) u_req_fifo (
      .clk   (clk),
      .rst_n (sys_rst),
      .push  (fifo_push),
      .pop   (pop),
      .wdata ({req_idx, l_k}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (q_level)
   );

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Done is checked before the watchdog so a completion on the terminal
   // count still counts as success.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      PLB_en     = 1'b0;
      PLB_addr   = '0;
      init       = '0;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (k_cnt < KW'(OPND_N)) begin
               PLB_en   = 1'b1;
               PLB_addr = opnd_base + stage_off + PLB_AW'(k_cnt);
            end
            if (k_cnt == KW'(OPND_N)) next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            init       = sel_mask;
            next_state = ST_RUN;
         end
         ST_RUN: begin
            if ((done & sel_mask) != '0) begin
               next_state = ST_IDLE;
            end else if (wd_cnt == WD_LAST) begin
               timeout    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // BRAM data lags the address by one cycle, so fetch slot k lands in word k-1.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cur_idx   <= '0;
         cur_lk    <= '0;
         k_cnt     <= '0;
         wd_cnt    <= '0;
         opnd_data <= '0;
         opnd_lk   <= '0;
         err       <= '0;
      end else begin
         if (stage_val != '0 && !req_onehot && !fifo_full) err[ERR_ONEHOT] <= 1'b1;
         if (timeout) err[ERR_TIMEOUT] <= 1'b1;
         if (pop) begin
            cur_idx <= fifo_rdata[EW-1:ROW_LEN];
            cur_lk  <= fifo_rdata[ROW_LEN-1:0];
         end
         if (state == ST_FETCH) begin
            k_cnt <= k_cnt + KW'(1);
            for (int w = 0; w < OPND_N; w++) begin
               if (k_cnt == KW'(w + 1)) opnd_data[w*DW +: DW] <= PLB_din;
            end
            if (next_state == ST_ISSUE) opnd_lk <= cur_lk;
         end else begin
            k_cnt <= '0;
         end
         if (state == ST_RUN && next_state == ST_RUN) wd_cnt <= wd_cnt + TO_W'(1);
         else                                          wd_cnt <= '0;
      end
   end

endmodule

// File: doc/ekf_stage_sched.md
Name: ekf_stage_sched

Overview:
Parametrised stage scheduler between the PS request interface and the non-linear/RSA engines of the EKF-SLAM datapath. It queues one-hot stage requests (predict/newlm/update, generalised to N_STAGE kinds) tagged with a landmark index, and fetches each stage's operands from PLB BRAM. It then fires a one-cycle init pulse to the selected engine and waits for that engine's done, with a watchdog. It generalises the fixed 3-stage val/rdy handshake to a buffered, timeout-protected, N-stage scheduler.

Parameters:
DW, 32, operand/data width
PLB_AW, 10, PLB BRAM address width
ROW_LEN, 10, landmark index width
N_STAGE, 3, number of stage kinds (bit 0 predict, 1 newlm, 2 update)
Q_DEPTH, 4, request queue depth (power of 2, >=2)
OPND_N, 2, operand words fetched per request
TO_W, 16, watchdog counter width

Ports:
clk  in  1  system clock
sys_rst  in  1  asynchronous, active-low reset
stage_val  in  N_STAGE  one-hot stage request
stage_rdy  out  N_STAGE  all bits = queue not full
l_k  in  ROW_LEN  landmark index, captured with the request
opnd_base  in  PLB_AW  base address of the operand region
PLB_en  out  1  BRAM read enable
PLB_we  out  1  constant 0
PLB_addr  out  PLB_AW  BRAM address
PLB_din  in  DW  BRAM read data, 1-cycle latency
init  out  N_STAGE  one-hot, one-cycle start pulse
opnd_data  out  OPND_N*DW  fetched operands; word k in bits [k*DW +: DW]
opnd_lk  out  ROW_LEN  landmark index of the active request
done  in  N_STAGE  engine completion pulses
busy  out  1  FSM not IDLE or queue non-empty
q_level  out  clog2(Q_DEPTH)+1  queue occupancy
err  out  2  sticky flags: [0] watchdog timeout, [1] non-one-hot request

Behaviour:
- Reset (sys_rst=0, asynchronous): queue empty, FSM IDLE. Outputs: init=0, PLB_en=0, PLB_addr=0, opnd_data=0, opnd_lk=0, err=0, busy=0, q_level=0, stage_rdy=all 1.
- Accept: on a clock edge where stage_val is exactly one-hot and the queue is not full, push {stage index, l_k}.
  - stage_val=0: no action.
  - Multi-hot stage_val: no push; err[1] set.
  - Any stage_val while full: no push, no error; the requester holds the request.
- stage_rdy depends only on the registered full flag. There is no bypass path. A pop on the same edge does not make a full queue accept.
- Push and pop on the same edge are both performed; q_level is unchanged.
- FSM states: IDLE, FETCH, ISSUE, RUN.
- IDLE: if the queue is non-empty, pop the head and go to FETCH.
- FETCH: lasts OPND_N+1 cycles, with a counter k running 0..OPND_N.
  - For k<OPND_N: PLB_en=1, PLB_addr = opnd_base + stage_idx*OPND_N + k, modulo 2^PLB_AW (wraps).
  - For k>=1: capture PLB_din into operand word k-1.
  - After capturing the last word, go to ISSUE.
- ISSUE: init[stage_idx]=1 for exactly one cycle; opnd_lk = popped l_k; go to RUN.
- opnd_data and opnd_lk are held stable from ISSUE until the next FETCH overwrites them.
- RUN: the watchdog counts up from 0.
  - done[stage_idx]=1: go to IDLE; counter cleared.
  - done on other bits: ignored.
  - Counter reaches 2^TO_W-1 without done: err[0] set, request dropped, go to IDLE.
  - done on the same edge as the terminal count: treated as success.
- Latency: request accepted at edge 0 into an empty queue with FSM idle → FETCH from edge 1 → init high in the cycle after edge OPND_N+2. With OPND_N=2, init is high between edges 4 and 5.
- Back-to-back requests: the next FETCH starts the cycle after the RUN→IDLE edge plus one IDLE cycle.
- err bits clear only on reset.
- Reset mid-operation: aborts immediately with no further init pulse. Queue contents are discarded.

Decomposition:
- Package ekf_sched_pkg: state enum (IDLE/FETCH/ISSUE/RUN), stage index constants (STG_PREDICT=0, STG_NEWLM=1, STG_UPDATE=2), err bit positions.
- Sub-module ekf_req_fifo: a synchronous FIFO (Q_DEPTH entries of clog2(N_STAGE)+ROW_LEN bits) with full/empty/level outputs.
- The FSM, address generation and watchdog live in the top module.

Test Plan:
- Reset: sys_rst low asynchronously mid-cycle → all outputs at reset values immediately; stage_rdy=3'b111.
- Single predict: opnd_base=0x100, BRAM[0x100]=0x11, [0x101]=0x22; stage_val=3'b001, l_k=5 at edge 0 → PLB_addr 0x100, 0x101 in cycles 1–2; init=3'b001 between edges 4–5; opnd_data={0x22,0x11}; opnd_lk=5; done[0] → busy=0.
- Update address and wrap: opnd_base=0x3FF, stage_val=3'b100 → addresses 0x003, 0x004; the wrap case opnd_base=0x3FE with stage 2 → addresses 0x002, 0x003 (modulo 1024).
- Back-pressure: 5 requests on consecutive cycles while the first is in RUN → 4 accepted, stage_rdy=0 and q_level=4 on the fifth; after done, the queue drains in order with matching l_k.
- Watchdog: TO_W=4, no done → err[0]=1 after 15 RUN cycles, FSM returns to IDLE and the next request proceeds. done[1] during a stage-0 RUN is ignored.
- Illegal request: stage_val=3'b011 → no push, q_level unchanged, err[1]=1. Reset during RUN → init stays 0 and the queue is emptied.
